// File: rtl/meas_pkg.sv
// Shared types and helpers for the measurement integrator: channel state
// encoding and a saturating signed add usable at any accumulator width.
package meas_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } chan_state_t;

  localparam int SAT_WORD      = 64;
  localparam int DEF_ACC_WIDTH = 32;
  localparam logic signed [DEF_ACC_WIDTH-1:0] DEF_ACC_MAX = {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_ACC_WIDTH-1:0] DEF_ACC_MIN = {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};

  // Operands arrive sign-extended to SAT_WORD; the result is clamped to the
  // signed range of a w-bit word (w must stay below SAT_WORD-1).
  function automatic logic signed [SAT_WORD-1:0] sat_add(
    input logic signed [SAT_WORD-1:0] a,
    input logic signed [SAT_WORD-1:0] b,
    input int                         w
  );
    logic signed [SAT_WORD-1:0] s;
    logic signed [SAT_WORD-1:0] hi;
    logic signed [SAT_WORD-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/meas_integrator_chan.sv
// One measurement channel: trigger-armed sample integration followed by a
// signed threshold decision, with a sticky overrun flag.
module meas_integrator_chan
  import meas_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    sample_valid,
  input  logic [LEN_WIDTH-1:0]    int_len,
  input  logic [ACC_WIDTH-1:0]    threshold,
  input  logic                    overrun_clr,
  output logic                    meas,
  output logic                    meas_valid,
  output logic                    busy,
  output logic                    overrun
);

  chan_state_t                 state, state_next;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, acc_sum;
  logic signed [ACC_WIDTH-1:0] thr_r, thr_next;
  logic [LEN_WIDTH-1:0]        count, count_next, count_inc;
  logic [LEN_WIDTH-1:0]        len_r, len_next;
  logic                        meas_next, meas_valid_next, overrun_next;
  logic signed [SAT_WORD-1:0]  sum_wide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      len_r      <= '0;
      thr_r      <= '0;
      meas       <= 1'b0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      count      <= count_next;
      len_r      <= len_next;
      thr_r      <= thr_next;
      meas       <= meas_next;
      meas_valid <= meas_valid_next;
      overrun    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state;
    acc_next        = acc;
    count_next      = count;
    len_next        = len_r;
    thr_next        = thr_r;
    meas_next       = meas;
    meas_valid_next = 1'b0;
    count_inc       = count + 1'b1;
    sum_wide        = sat_add(64'(acc), 64'($signed(sample)), ACC_WIDTH);
    acc_sum         = sum_wide[ACC_WIDTH-1:0];
    // A fresh overrun outranks a simultaneous clear.
    overrun_next    = (overrun & ~overrun_clr) | (trig & (state == ACCUM));

    unique case (state)
      IDLE: begin
        if (trig) begin
          len_next   = int_len;
          thr_next   = $signed(threshold);
          acc_next   = '0;
          count_next = '0;
          if (int_len != '0) begin
            state_next = ACCUM;
          end else begin
            // Empty window: the decision is on a zero sum against the new threshold.
            meas_valid_next = 1'b1;
            meas_next       = threshold[ACC_WIDTH-1] | (threshold == '0);
          end
        end
      end
      ACCUM: begin
        if (sample_valid) begin
          acc_next   = acc_sum;
          count_next = count_inc;
          if (count_inc == len_r) begin
            meas_next       = (acc_sum >= thr_r);
            meas_valid_next = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == ACCUM);

endmodule

// File: rtl/meas_integrator.sv
// Bank of independent integrate-and-threshold channels turning demodulated
// readout samples into per-channel measurement bits.
module meas_integrator
  import meas_pkg::*;
#(
  parameter int N_MEAS       = 5,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_MEAS-1:0]              trig,
  input  logic [N_MEAS*SAMPLE_WIDTH-1:0] sample,
  input  logic [N_MEAS-1:0]              sample_valid,
  input  logic [N_MEAS*LEN_WIDTH-1:0]    int_len,
  input  logic [N_MEAS*ACC_WIDTH-1:0]    threshold,
  input  logic [N_MEAS-1:0]              overrun_clr,
  output logic [N_MEAS-1:0]              meas,
  output logic [N_MEAS-1:0]              meas_valid,
  output logic [N_MEAS-1:0]              busy,
  output logic [N_MEAS-1:0]              overrun
);

  for (genvar gi = 0; gi < N_MEAS; gi++) begin : g_chan
    meas_integrator_chan #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .LEN_WIDTH   (LEN_WIDTH)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .trig        (trig[gi]),
      .sample      (sample[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .sample_valid(sample_valid[gi]),
      .int_len     (int_len[gi*LEN_WIDTH +: LEN_WIDTH]),
      .threshold   (threshold[gi*ACC_WIDTH +: ACC_WIDTH]),
      .overrun_clr (overrun_clr[gi]),
      .meas        (meas[gi]),
      .meas_valid  (meas_valid[gi]),
      .busy        (busy[gi]),
      .overrun     (overrun[gi])
    );
  end

endmodule

// File: tb/tb_meas_integrator.sv
// Directed-vector bench for meas_integrator with hand-computed expectations.
module tb_meas_integrator;

  localparam int N  = 5;
  localparam int SW = 16;
  localparam int AW = 20;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      trig;
  logic [N*SW-1:0]   sample;
  logic [N-1:0]      sample_valid;
  logic [N*LW-1:0]   int_len;
  logic [N*AW-1:0]   threshold;
  logic [N-1:0]      overrun_clr;
  logic [N-1:0]      meas, meas_valid, busy, overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  meas_integrator #(
    .N_MEAS(N), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset), .trig(trig), .sample(sample),
    .sample_valid(sample_valid), .int_len(int_len), .threshold(threshold),
    .overrun_clr(overrun_clr), .meas(meas), .meas_valid(meas_valid),
    .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int len, input int thr);
    int_len[ch*LW +: LW]   = len[LW-1:0];
    threshold[ch*AW +: AW] = thr[AW-1:0];
  endtask

  task automatic set_sample(input int ch, input int val);
    sample[ch*SW +: SW] = val[SW-1:0];
  endtask

  // Trigger a window and confirm the channel went busy.
  task automatic start(input int ch, input int len, input int thr);
    set_cfg(ch, len, thr);
    trig[ch] = 1'b1;
    tick();
    trig[ch] = 1'b0;
    check($sformatf("start_busy ch%0d", ch), 64'(busy[ch]), 64'(len != 0));
  endtask

  task automatic feed(input int ch, input int val);
    set_sample(ch, val);
    sample_valid[ch] = 1'b1;
    tick();
    sample_valid[ch] = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    trig         = '0;
    sample       = '0;
    sample_valid = '0;
    int_len      = '0;
    threshold    = '0;
    overrun_clr  = '0;
    tick(); tick();
    check("rst_meas", 64'(meas), 64'(0));
    check("rst_valid", 64'(meas_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    reset = 1'b1;
    tick();

    // Basic: 3+3+3+3 = 12 >= 10
    start(0, 4, 10);
    for (int i = 0; i < 3; i++) begin
      feed(0, 3);
      check("basic_busy", 64'(busy[0]), 64'(1));
      check("basic_nov", 64'(meas_valid[0]), 64'(0));
    end
    feed(0, 3);
    check("basic_valid", 64'(meas_valid[0]), 64'(1));
    check("basic_meas", 64'(meas[0]), 64'(1));
    check("basic_idle", 64'(busy[0]), 64'(0));
    tick();
    check("basic_pulse", 64'(meas_valid[0]), 64'(0));

    // 2+2+2+2 = 8 < 10
    start(0, 4, 10);
    for (int i = 0; i < 4; i++) feed(0, 2);
    check("low_valid", 64'(meas_valid[0]), 64'(1));
    check("low_meas", 64'(meas[0]), 64'(0));
    tick();

    // Gapped, equality: -2 + -2 + -1 = -5 >= -5
    start(0, 3, -5);
    feed(0, -2);
    tick(); tick();
    check("gap_busy", 64'(busy[0]), 64'(1));
    feed(0, -2);
    check("gap_nov", 64'(meas_valid[0]), 64'(0));
    feed(0, -1);
    check("gap_valid", 64'(meas_valid[0]), 64'(1));
    check("gap_meas", 64'(meas[0]), 64'(1));
    tick();
    check("gap_pulse", 64'(meas_valid[0]), 64'(0));
    check("gap_hold", 64'(meas[0]), 64'(1));

    // Positive saturation: 40*32767 clamps to 524287
    start(0, 40, 524287);
    for (int i = 0; i < 39; i++) feed(0, 32767);
    check("satp_nov", 64'(meas_valid[0]), 64'(0));
    feed(0, 32767);
    check("satp_valid", 64'(meas_valid[0]), 64'(1));
    check("satp_meas", 64'(meas[0]), 64'(1));
    check("satp_acc", 64'(dut.g_chan[0].u_chan.acc), 64'(20'h7FFFF));
    tick();

    // Negative saturation: clamps to -524288
    start(0, 40, -524288);
    for (int i = 0; i < 40; i++) feed(0, -32768);
    check("satn_valid", 64'(meas_valid[0]), 64'(1));
    check("satn_meas", 64'(meas[0]), 64'(1));
    tick();

    // Overrun on ch2: mid-window trig with a different config is ignored
    start(2, 3, 5);
    feed(2, 2);
    set_cfg(2, 1, 100);
    trig[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    check("ovr_set", 64'(overrun[2]), 64'(1));
    check("ovr_busy", 64'(busy[2]), 64'(1));
    feed(2, 2);
    feed(2, 2);
    check("ovr_valid", 64'(meas_valid[2]), 64'(1));
    check("ovr_meas", 64'(meas[2]), 64'(1));
    tick();
    check("ovr_held", 64'(overrun[2]), 64'(1));
    overrun_clr[2] = 1'b1;
    tick();
    overrun_clr[2] = 1'b0;
    check("ovr_clr", 64'(overrun[2]), 64'(0));

    // Clear and new overrun in the same cycle: set wins
    start(2, 2, 0);
    trig[2] = 1'b1;
    overrun_clr[2] = 1'b1;
    tick();
    trig[2] = 1'b0;
    overrun_clr[2] = 1'b0;
    check("ovr_setwins", 64'(overrun[2]), 64'(1));
    overrun_clr[2] = 1'b1;
    feed(2, 1);
    overrun_clr[2] = 1'b0;
    check("ovr_clr2", 64'(overrun[2]), 64'(0));
    // Trig in the final-sample cycle: overrun set, window still completes
    trig[2] = 1'b1;
    feed(2, -1);
    trig[2] = 1'b0;
    check("ovr_final_set", 64'(overrun[2]), 64'(1));
    check("ovr_final_valid", 64'(meas_valid[2]), 64'(1));
    check("ovr_final_meas", 64'(meas[2]), 64'(1));
    check("ovr_final_idle", 64'(busy[2]), 64'(0));
    tick();

    // Zero length: 0 >= 1 is false
    start(3, 0, 1);
    check("zero_valid", 64'(meas_valid[3]), 64'(1));
    check("zero_meas", 64'(meas[3]), 64'(0));
    tick();
    check("zero_pulse", 64'(meas_valid[3]), 64'(0));

    // Sample valid alongside the trig is not counted
    set_cfg(4, 1, 50);
    set_sample(4, 100);
    sample_valid[4] = 1'b1;
    trig[4] = 1'b1;
    tick();
    trig[4] = 1'b0;
    sample_valid[4] = 1'b0;
    check("trigsv_busy", 64'(busy[4]), 64'(1));
    check("trigsv_nov", 64'(meas_valid[4]), 64'(0));
    feed(4, 10);
    check("trigsv_valid", 64'(meas_valid[4]), 64'(1));
    check("trigsv_meas", 64'(meas[4]), 64'(0));
    tick(); tick();

    // Independence: ch k triggers at cycle k, length k+1, samples of 1.
    // Valid lands after edge 2k+1; even channels meet threshold, odd miss by one.
    for (int k = 0; k < N; k++) begin
      set_cfg(k, k + 1, (k % 2 == 0) ? k + 1 : k + 2);
      set_sample(k, 1);
    end
    overrun_clr = '1;
    sample_valid = '1;
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < N; k++) trig[k] = (c == k);
      tick();
      overrun_clr = '0;
      for (int k = 0; k < N; k++) begin
        check($sformatf("indep c%0d ch%0d valid", c, k), 64'(meas_valid[k]), 64'(c == 2 * k + 1));
        if (c == 2 * k + 1)
          check($sformatf("indep ch%0d meas", k), 64'(meas[k]), 64'(k % 2 == 0));
      end
    end
    trig = '0;
    sample_valid = '0;
    check("indep_overrun", 64'(overrun), 64'(0));
    tick();

    // Reset mid-window on ch1
    start(1, 10, 0);
    for (int i = 0; i < 3; i++) feed(1, 1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_meas", 64'(meas), 64'(0));
    check("midrst_valid", 64'(meas_valid), 64'(0));
    check("midrst_overrun", 64'(overrun), 64'(0));
    tick();
    reset = 1'b1;
    set_sample(1, 1);
    sample_valid[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("postrst %0d valid", i), 64'(meas_valid[1]), 64'(0));
      check($sformatf("postrst %0d busy", i), 64'(busy[1]), 64'(0));
    end
    sample_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
